// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, inverse S-box and GF(2^8) helpers
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } inv_fsm_t;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic byte_t gf_xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product by shift-and-add over the bits of b.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Row r is rotated right by r columns; byte index is r + 4*c.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {0e,0b,0d,09}.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_round.sv
// rtl/inv_round.sv - combinational AES inverse round (last round skips InvMixColumns)
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] w_shifted;
  logic [127:0] w_subbed;
  logic [127:0] w_keyed;

  // InvShiftRows, byte-wise InvSubBytes, AddRoundKey, then optional InvMixColumns.
  always_comb begin
    w_shifted = inv_shift_rows(i_state);
    w_subbed  = '0;
    for (int i = 0; i < 16; i++) begin
      w_subbed[127-8*i -: 8] = INV_SBOX[w_shifted[127-8*i -: 8]];
    end
    w_keyed = w_subbed ^ i_key;
    o_state = i_last ? w_keyed : inv_mix_columns(w_keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// rtl/aes_inv_cipher_seq.sv - iterative AES inverse cipher, one round per clock
module aes_inv_cipher_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  generate
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
      $error("aes_inv_cipher_seq: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [3:0] RND_START = 4'(NR - 1);

  inv_fsm_t     r_fsm;
  inv_fsm_t     w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic [127:0] w_round_out;
  logic         w_last;

  assign w_last = (r_rnd == 4'd0);

  inv_round u_inv_round (
    .i_state (r_state),
    .i_key   (rk_data),
    .i_last  (w_last),
    .o_state (w_round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Next state, handshake outputs and round-key index.
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    out_data  = '0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = NR_IDX;
        if (in_valid) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        rk_idx = r_rnd;
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_data  = r_state;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Round counter and cipher state; the state only moves on accept or in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_rnd   <= 4'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ rk_data;
            r_rnd   <= RND_START;
          end
        end
        S_ROUND: begin
          r_state <= w_round_out;
          if (!w_last) r_rnd <= r_rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// tb/tb_aes_inv_cipher_seq.sv - self-checking bench for the iterative AES inverse cipher
module tb_aes_inv_cipher_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [127:0] rk_mem [16];
  logic [7:0]   sbox [256];

  int n_checks;
  int n_pass;

  assign rk_data = rk_mem[rk_idx];

  aes_inv_cipher_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // Forward S-box from the multiplicative inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // AES-128 key schedule into rk_mem[0..10].
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Forward cipher on a byte array; its inverse is what the DUT must compute.
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = mul(t[4*c],8'h02) ^ mul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(t[4*c+1],8'h02) ^ mul(t[4*c+2],8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2],8'h02) ^ mul(t[4*c+3],8'h03);
          s[4*c+3] = mul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3],8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag,
                           input bit hold_valid, input int bp_cycles, input bit do_trace);
    int         edges;
    logic [3:0] exp_idx;
    @(negedge clk);
    in_data  = ct;
    in_valid = 1'b1;
    check({tag, ":in_ready_idle"}, 128'(in_ready), 128'd1);
    if (do_trace) check({tag, ":rk_trace_idle"}, 128'(rk_idx), 128'd10);
    @(posedge clk);
    #1;
    edges   = 1;
    exp_idx = 4'd9;
    if (hold_valid) in_data = rand128(); else in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      if (do_trace) begin
        check($sformatf("%s:rk_trace%0d", tag, edges), 128'(rk_idx), 128'(exp_idx));
        exp_idx = exp_idx - 4'd1;
      end
      @(posedge clk);
      #1;
      edges++;
      if (hold_valid) in_data = rand128();
    end
    check({tag, ":latency"}, 128'(edges), 128'd11);
    check({tag, ":out_valid"}, 128'(out_valid), 128'd1);
    check({tag, ":out_data"}, out_data, pt);
    check({tag, ":in_ready_done"}, 128'(in_ready), 128'd0);
    for (int k = 0; k < bp_cycles; k++) begin
      @(posedge clk);
      #1;
      if (hold_valid) in_data = rand128();
      check($sformatf("%s:bp%0d_valid", tag, k), 128'(out_valid), 128'd1);
      check($sformatf("%s:bp%0d_data", tag, k), out_data, pt);
      check($sformatf("%s:bp%0d_in_ready", tag, k), 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ":released"}, {127'd0, out_valid}, 128'd0);
    check({tag, ":idle_again"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    int           guard;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    #12;
    check("reset:out_valid", 128'(out_valid), 128'd0);
    check("reset:out_data", out_data, 128'd0);
    check("reset:in_ready", 128'(in_ready), 128'd1);
    check("reset:rk_idx", 128'(rk_idx), 128'd10);
    @(negedge clk);
    rst = 1'b0;

    check("model:rk10", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff,
              "fips_c1", 1'b0, 0, 1'b1);

    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734,
              "fips_b", 1'b0, 5, 1'b0);

    for (int b = 0; b < 3; b++) begin
      pt = rand128();
      run_block(model_encrypt(pt), pt, $sformatf("hold%0d", b), 1'b1, b, 1'b0);
    end

    // Abandon a block at rnd = 5 with an asynchronous reset pulse.
    pt = rand128();
    ct = model_encrypt(pt);
    @(negedge clk);
    in_data  = ct;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (rk_idx !== 4'd5 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst:reach_rnd5", 128'(rk_idx), 128'd5);
    #2;
    rst = 1'b1;
    #1;
    check("rst:out_valid", 128'(out_valid), 128'd0);
    check("rst:in_ready", 128'(in_ready), 128'd1);
    check("rst:out_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(ct, pt, "after_rst", 1'b0, 0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      expand_key(rand128());
      for (int b = 0; b < 2; b++) begin
        pt = rand128();
        run_block(model_encrypt(pt), pt, $sformatf("rand_k%0d_b%0d", k, b), 1'(b), b, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
